// File: rtl/jpeg_rle_pkg.sv
// Shared types, constants and the amplitude decoder for the JPEG run-length decoder.
package jpeg_rle_pkg;

  localparam int unsigned DEC_W = 12;  // widest decoded amplitude: size 11 plus sign
  localparam logic [5:0]  BLK_LAST = 6'd63;
  localparam logic [3:0]  SIZE_MAX = 4'd11;
  localparam logic [7:0]  EOB = 8'h00;  // {rlen, size}
  localparam logic [7:0]  ZRL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AC,
    ST_RUN,
    ST_FILL
  } rle_st_t;

  // JPEG size/amplitude to two's complement; oversize categories decode as 11.
  function automatic logic signed [DEC_W-1:0] amp_decode(input logic [3:0]       size,
                                                         input logic [DEC_W-1:0] amp);
    logic [3:0]       s;
    logic [DEC_W-1:0] mask;
    logic [DEC_W-1:0] val;
    s    = (size > SIZE_MAX) ? SIZE_MAX : size;
    mask = (DEC_W'(1) << s) - DEC_W'(1);
    val  = amp & mask;
    if (s == 4'd0) return '0;
    if (amp[s - 4'd1]) return signed'(val);
    return signed'(val - mask);
  endfunction

endpackage

// File: rtl/jpeg_rle_decoder.sv
// Expands (rlen, size, amp) tuples into one zig-zag ordered coefficient per clock,
// restoring zero runs and undoing DC differential prediction.
module jpeg_rle_decoder
  import jpeg_rle_pkg::*;
#(
  parameter int unsigned BLK_LEN = 64,
  parameter int unsigned AW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          dc_clr,
  input  logic          den,
  input  logic          dstrb,
  input  logic [3:0]    rlen,
  input  logic [3:0]    size,
  input  logic [AW-1:0] amp,
  output logic          rdy,
  output logic [AW-1:0] dout,
  output logic          douten,
  output logic [5:0]    dpos,
  output logic          dlast,
  output logic          err
);

  localparam int unsigned POS_W = $clog2(BLK_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(BLK_LAST);

  rle_st_t          state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [AW-1:0]    pred_q, pred_d;
  logic [AW-1:0]    coef_q, coef_d;
  logic             rdy_q, rdy_d;
  logic [AW-1:0]    dout_q, dout_d;
  logic             douten_q, douten_d;
  logic [5:0]       dpos_q, dpos_d;
  logic             dlast_q, dlast_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             size_bad_c;
  logic [AW-1:0]    dec_c;
  logic [AW-1:0]    dc_val_c;
  logic             emit_c;
  logic [POS_W-1:0] emit_pos_c;
  logic [AW-1:0]    emit_val_c;
  logic             more_c;

  assign accept_c   = den && rdy_q;
  assign size_bad_c = size > SIZE_MAX;
  assign dec_c      = AW'(amp_decode(size, DEC_W'(amp)));
  assign dc_val_c   = (dc_clr ? '0 : pred_q) + dec_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      pos_q    <= '0;
      pred_q   <= '0;
      coef_q   <= '0;
      rdy_q    <= 1'b0;
      dout_q   <= '0;
      douten_q <= 1'b0;
      dpos_q   <= '0;
      dlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      run_q    <= run_d;
      pos_q    <= pos_d;
      pred_q   <= pred_d;
      coef_q   <= coef_d;
      rdy_q    <= rdy_d;
      dout_q   <= dout_d;
      douten_q <= douten_d;
      dpos_q   <= dpos_d;
      dlast_q  <= dlast_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    pos_d      = pos_q;
    pred_d     = pred_q;
    coef_d     = coef_q;
    rdy_d      = 1'b0;
    dout_d     = '0;
    douten_d   = 1'b0;
    dpos_d     = dpos_q;
    dlast_d    = 1'b0;
    err_d      = 1'b0;
    emit_c     = 1'b0;
    emit_pos_c = pos_q;
    emit_val_c = '0;
    more_c     = 1'b0;

    if (dc_clr) pred_d = '0;
    if (accept_c && size_bad_c) err_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_AC: begin
        if (accept_c) begin
          if (dstrb) begin
            // A DC tuple always opens a new block; inside AC it aborts the current one.
            err_d      = err_d | (state_q == ST_AC);
            pred_d     = dc_val_c;
            emit_c     = 1'b1;
            emit_pos_c = '0;
            emit_val_c = dc_val_c;
            state_d    = ST_AC;
          end else if (state_q == ST_IDLE) begin
            err_d = 1'b1;
          end else if ({rlen, size} == EOB) begin
            emit_c  = 1'b1;
            state_d = ST_FILL;
          end else if (rlen == 4'd0) begin
            emit_c     = 1'b1;
            emit_val_c = dec_c;
          end else begin
            // First zero of the run goes out now; ZRL is a 15-run with a zero coefficient.
            emit_c  = 1'b1;
            more_c  = 1'b1;
            run_d   = rlen - 4'd1;
            coef_d  = dec_c;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        emit_c = 1'b1;
        if (run_q != 4'd0) begin
          more_c = 1'b1;
          run_d  = run_q - 4'd1;
        end else begin
          emit_val_c = coef_q;
          state_d    = ST_AC;
        end
      end
      ST_FILL: emit_c = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // Emission and block-end handling; anything still pending at the last slot is an overrun.
    if (emit_c) begin
      douten_d = 1'b1;
      dout_d   = emit_val_c;
      dpos_d   = 6'(emit_pos_c);
      pos_d    = emit_pos_c + POS_W'(1);
      if (emit_pos_c == POS_LAST) begin
        dlast_d = 1'b1;
        err_d   = err_d | more_c;
        state_d = ST_IDLE;
        pos_d   = '0;
      end
    end

    rdy_d = (state_d == ST_IDLE) || (state_d == ST_AC);
  end

  assign rdy    = rdy_q;
  assign dout   = dout_q;
  assign douten = douten_q;
  assign dpos   = dpos_q;
  assign dlast  = dlast_q;
  assign err    = err_q;

endmodule

// File: tb/tb_jpeg_rle_decoder.sv
// Self-checking bench for jpeg_rle_decoder against a tuple-level block model.
module tb_jpeg_rle_decoder;

  typedef struct packed {
    logic [11:0] v;
    logic [5:0]  p;
    logic        l;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        dc_clr = 1'b0;
  logic        den = 1'b0;
  logic        dstrb = 1'b0;
  logic [3:0]  rlen = '0;
  logic [3:0]  size = '0;
  logic [11:0] amp = '0;
  logic        rdy;
  logic [11:0] dout;
  logic        douten;
  logic [5:0]  dpos;
  logic        dlast;
  logic        err;

  int   n_assert = 0;
  int   n_fail = 0;
  bit   ena_rand = 1'b0;
  rec_t act_q[$];
  rec_t exp_q[$];
  int   act_err = 0;
  int   exp_err = 0;
  int   last_wait = 0;

  // Reference model state: whether a block is open, next position, DC predictor.
  bit   in_blk = 1'b0;
  int   mpos = 0;
  int   pred = 0;

  jpeg_rle_decoder #(.BLK_LEN(64), .AW(12)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dc_clr(dc_clr), .den(den), .dstrb(dstrb),
    .rlen(rlen), .size(size), .amp(amp), .rdy(rdy), .dout(dout), .douten(douten),
    .dpos(dpos), .dlast(dlast), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input int s, input int a);
    int ss;
    int m;
    ss = (s > 11) ? 11 : s;
    if (ss == 0) return 0;
    m = a % (1 << ss);
    if (m >= (1 << (ss - 1))) return m;
    return m - ((1 << ss) - 1);
  endfunction

  function automatic void push(input int val, input int pos, input bit last);
    exp_q.push_back('{v: 12'(val), p: 6'(pos), l: last});
  endfunction

  task automatic model_tuple(input bit ds, input int r, input int s, input int a, input bit clr);
    int v;
    bit e;
    e = (s > 11);
    v = dec(s, a);
    if (ds) begin
      if (in_blk) e = 1'b1;
      if (clr) pred = 0;
      pred   = (pred + v) & 'hFFF;
      push(pred, 0, 1'b0);
      in_blk = 1'b1;
      mpos   = 1;
    end else if (!in_blk) begin
      e = 1'b1;
    end else if (r == 0 && s == 0) begin
      for (int p = mpos; p < 64; p++) push(0, p, p == 63);
      in_blk = 1'b0;
    end else begin
      for (int k = 0; k <= r; k++) begin
        push((k == r) ? v : 0, mpos, mpos == 63);
        if (mpos == 63) begin
          if (k < r) exp_err++;
          in_blk = 1'b0;
          break;
        end
        mpos++;
      end
    end
    if (e) exp_err++;
  endtask

  // One clock: advance, choose ena for the new cycle, record what downstream consumes.
  task automatic cycle();
    @(posedge clk);
    #1;
    ena = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (ena && douten) act_q.push_back('{v: dout, p: dpos, l: dlast});
    if (ena && err) act_err++;
  endtask

  task automatic send(input bit ds, input int r, input int s, input int a, input bit clr);
    bit acc;
    den = 1'b1; dstrb = ds; rlen = 4'(r); size = 4'(s); amp = 12'(a); dc_clr = clr;
    acc = 1'b0;
    last_wait = 0;
    while (!acc && last_wait < 300) begin
      acc = rdy && ena;
      cycle();
      if (!acc) last_wait++;
    end
    den = 1'b0; dc_clr = 1'b0;
    chk("tuple accepted", 32'(acc), 32'd1);
    if (acc) model_tuple(ds, r, s, a, clr);
  endtask

  task automatic clr_pred();
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    dc_clr = 1'b1;
    while (!acc && n < 50) begin
      acc = ena;
      cycle();
      n++;
    end
    dc_clr = 1'b0;
    pred = 0;
  endtask

  task automatic wait_out(input bit need_rdy);
    int n;
    n = 0;
    while ((act_q.size() < exp_q.size() || (need_rdy && !rdy)) && n < 600) begin
      cycle();
      n++;
    end
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (3) cycle();
    chk({tag, " count"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d] dout", tag, i), 32'(act_q[i].v), 32'(exp_q[i].v));
      chk($sformatf("%s[%0d] dpos", tag, i), 32'(act_q[i].p), 32'(exp_q[i].p));
      chk($sformatf("%s[%0d] dlast", tag, i), 32'(act_q[i].l), 32'(exp_q[i].l));
    end
    chk({tag, " err pulses"}, 32'(act_err), 32'(exp_err));
    act_q.delete(); exp_q.delete();
    act_err = 0; exp_err = 0;
  endtask

  initial begin
    int n;
    int x;
    // Reset state
    repeat (2) cycle();
    chk("reset douten", 32'(douten), 32'd0);
    chk("reset rdy", 32'(rdy), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset dpos", 32'(dpos), 32'd0);
    chk("reset dlast", 32'(dlast), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst = 1'b1;
    cycle();
    chk("rdy after reset", 32'(rdy), 32'd1);

    // DC -5 then EOB fill
    send(1, 0, 3, 3'b010, 0);
    send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 63) begin
      chk("t1 dc value", 32'(act_q[0].v), 32'hFFB);
      chk("t1 last pos", 32'(act_q[63].p), 32'd63);
    end
    compare("t1");

    // DC prediction across blocks, then with predictor clears
    clr_pred();
    send(1, 0, 4, 10, 0); send(0, 0, 0, 0, 0);
    send(1, 0, 3, 3, 0);  send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 64) chk("t2 dc second", 32'(act_q[64].v), 32'd6);
    compare("t2");
    send(1, 0, 4, 10, 1); send(0, 0, 0, 0, 0);
    clr_pred();
    send(1, 0, 3, 3, 0);  send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 64) chk("t2c dc second", 32'(act_q[64].v), 32'hFFC);
    compare("t2c");

    // Run of 2, rdy low for exactly two cycles
    send(1, 0, 0, 0, 0);
    send(0, 2, 2, 3, 0);
    n = 0;
    while (!rdy && n < 10) begin n++; cycle(); end
    chk("t3 rdy low cycles", 32'(n), 32'd2);
    send(0, 0, 1, 0, 0);
    send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 4) begin
      chk("t3 dpos3", 32'(act_q[3].v), 32'd3);
      chk("t3 dpos4", 32'(act_q[4].v), 32'hFFF);
    end
    compare("t3");

    // Three ZRLs plus a run reaching slot 63 exactly, next DC without EOB
    send(1, 0, 1, 1, 0);
    repeat (3) send(0, 15, 0, 0, 0);
    send(0, 14, 1, 1, 0);
    wait_out(0);
    chk("t4 rdy at block end", 32'(rdy), 32'd1);
    send(1, 0, 1, 1, 0);
    chk("t4 next dc wait", 32'(last_wait), 32'd0);
    send(0, 0, 0, 0, 0);
    wait_out(1);
    compare("t4");

    // Overrun: run from slot 61 past the end
    send(1, 0, 2, 2, 0);
    repeat (3) send(0, 15, 0, 0, 0);
    send(0, 11, 1, 1, 0);
    send(0, 15, 1, 1, 0);
    wait_out(1);
    compare("t5");

    // Dropped AC in IDLE, oversize category, aborted block
    send(0, 0, 1, 1, 0);
    send(1, 0, 1, 1, 0);
    send(0, 0, 13, 'h0F0, 0);
    send(1, 0, 2, 2, 0);
    send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 1) chk("t6 oversize value", 32'(act_q[1].v), 32'h8F1);
    compare("t6");

    // Random blocks with random clock enable
    ena_rand = 1'b1;
    for (int b = 0; b < 8; b++) begin
      send(1, 0, $urandom_range(0, 11), $urandom_range(0, 4095), $urandom_range(0, 3) == 0);
      for (int t = 0; t < 40 && in_blk; t++) begin
        x = $urandom_range(0, 9);
        if (x == 0) send(0, 0, 0, 0, 0);
        else if (x == 1) send(0, 15, 0, 0, 0);
        else send(0, $urandom_range(0, 15), $urandom_range(1, 11), $urandom_range(0, 4095), 0);
      end
      if (in_blk) send(0, 0, 0, 0, 0);
    end
    wait_out(1);
    compare("rand");

    // Reset in the middle of a run
    send(1, 0, 2, 3, 0);
    send(0, 12, 5, 17, 0);
    repeat (3) cycle();
    ena_rand = 1'b0;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();
    chk("midrst douten", 32'(douten), 32'd0);
    chk("midrst rdy", 32'(rdy), 32'd0);
    chk("midrst dout", 32'(dout), 32'd0);
    chk("midrst dpos", 32'(dpos), 32'd0);
    chk("midrst dlast", 32'(dlast), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst prefix len", 32'(act_q.size() <= exp_q.size()), 32'd1);
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk($sformatf("midrst[%0d]", i), 32'(act_q[i]), 32'(exp_q[i]));
    act_q.delete(); exp_q.delete();
    act_err = 0; exp_err = 0;
    in_blk = 1'b0; pred = 0; mpos = 0;
    rst = 1'b1;
    cycle();
    chk("midrst rdy release", 32'(rdy), 32'd1);
    ena_rand = 1'b1;
    send(1, 0, 4, 9, 0);
    send(0, 0, 2, 1, 0);
    send(0, 0, 0, 0, 0);
    wait_out(1);
    if (act_q.size() > 0) chk("midrst dc pred0", 32'(act_q[0].v), 32'd9);
    compare("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
